// File: rtl/fixed_point_pkg.sv
// Shared fixed-point arithmetic definitions: default Q-format geometry and
// sequencer state encodings for the multiplier and the divider.
package fixed_point_pkg;

  localparam int Q_BITS_DEF  = 10;
  localparam int D_WIDTH_DEF = 32;

  localparam int DIV_Q_BITS_DEF  = 10;
  localparam int DIV_D_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mult_state_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/fixed_round_sat.sv
// Converts a double-width unsigned magnitude plus sign into a signed Q-format
// word, rounding half-up on the magnitude and saturating at the signed limits.
module fixed_round_sat #(
  parameter int Q_BITS  = 10,
  parameter int D_WIDTH = 32
) (
  input  logic [2*D_WIDTH-1:0] mag,
  input  logic                 sign,
  output logic [D_WIDTH-1:0]   result
);

  localparam int MW = 2 * D_WIDTH;
  localparam logic [MW-1:0] HALF    = {{(MW-1){1'b0}}, 1'b1} << (Q_BITS - 1);
  localparam logic [MW-1:0] POS_MAX = {{(D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic [MW-1:0] NEG_MAX = {{D_WIDTH{1'b0}}, 1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [D_WIDTH-1:0] ONE_D = {{(D_WIDTH-1){1'b0}}, 1'b1};

  logic [MW-1:0] rounded_s;
  logic [MW-1:0] shifted_s;

  assign rounded_s = mag + HALF;
  assign shifted_s = rounded_s >> Q_BITS;

  // Negative side may reach one step further than positive (two's complement).
  always_comb begin
    result = {D_WIDTH{1'b0}};
    if (sign) begin
      if (shifted_s > NEG_MAX) begin
        result = {1'b1, {(D_WIDTH-1){1'b0}}};
      end else begin
        result = ~shifted_s[D_WIDTH-1:0] + ONE_D;
      end
    end else begin
      if (shifted_s > POS_MAX) begin
        result = {1'b0, {(D_WIDTH-1){1'b1}}};
      end else begin
        result = shifted_s[D_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fixed_multiply.sv
// Sequential signed Q-format multiplier: one radix-2 shift-add step per cycle
// on operand magnitudes, then round and saturate into a registered product.
module fixed_multiply
  import fixed_point_pkg::*;
#(
  parameter int Q_BITS  = Q_BITS_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [D_WIDTH-1:0] multiplicand,
  input  logic [D_WIDTH-1:0] multiplier,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [D_WIDTH-1:0] product,
  output logic               valid_out
);

  localparam int CW = $clog2(D_WIDTH) + 1;
  localparam logic [CW-1:0]      LAST_CNT = CW'(D_WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [D_WIDTH-1:0] ONE_D    = {{(D_WIDTH-1){1'b0}}, 1'b1};

  mult_state_t          state_r;
  logic [2*D_WIDTH-1:0] acc_r;
  logic [2*D_WIDTH-1:0] mcand_r;
  logic [D_WIDTH-1:0]   mplr_r;
  logic [CW-1:0]        cnt_r;
  logic                 sign_r;
  logic                 ready_r;
  logic                 valid_r;
  logic [D_WIDTH-1:0]   product_r;

  logic [D_WIDTH-1:0]   a_mag_s;
  logic [D_WIDTH-1:0]   b_mag_s;
  logic [2*D_WIDTH-1:0] acc_next_s;
  logic [D_WIDTH-1:0]   result_s;

  // Magnitudes of the incoming operands; the most negative value maps onto
  // its exact unsigned magnitude because the field is D_WIDTH bits unsigned.
  always_comb begin
    if (multiplicand[D_WIDTH-1]) begin
      a_mag_s = ~multiplicand + ONE_D;
    end else begin
      a_mag_s = multiplicand;
    end
    if (multiplier[D_WIDTH-1]) begin
      b_mag_s = ~multiplier + ONE_D;
    end else begin
      b_mag_s = multiplier;
    end
  end

  // Partial-product accumulation for the current step.
  always_comb begin
    if (mplr_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  fixed_round_sat #(
    .Q_BITS (Q_BITS),
    .D_WIDTH(D_WIDTH)
  ) u_round_sat (
    .mag   (acc_next_s),
    .sign  (sign_r),
    .result(result_s)
  );

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      acc_r     <= {(2*D_WIDTH){1'b0}};
      mcand_r   <= {(2*D_WIDTH){1'b0}};
      mplr_r    <= {D_WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      sign_r    <= 1'b0;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      product_r <= {D_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (valid_in) begin
            mcand_r <= {{D_WIDTH{1'b0}}, a_mag_s};
            mplr_r  <= b_mag_s;
            sign_r  <= multiplicand[D_WIDTH-1] ^ multiplier[D_WIDTH-1];
            acc_r   <= {(2*D_WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b0;
            state_r <= BUSY;
          end else begin
            ready_r <= 1'b1;
          end
        end
        BUSY: begin
          acc_r   <= acc_next_s;
          mcand_r <= mcand_r << 1'b1;
          mplr_r  <= mplr_r >> 1'b1;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            product_r <= result_s;
            valid_r   <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready_out = ready_r;
  assign product   = product_r;
  assign valid_out = valid_r;

endmodule

// File: tb/tb_fixed_multiply.sv
// Self-checking bench for fixed_multiply (D_WIDTH=32, Q_BITS=10) against an
// arithmetic reference model of signed Q-format round-half-up multiplication.
module tb_fixed_multiply;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] product;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fixed_multiply dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .product     (product),
    .valid_out   (valid_out)
  );

  // Real-number view: (A/1024)*(B/1024), rounded half-up in magnitude, clamped.
  function automatic logic [31:0] model_mult(input logic [31:0] a, input logic [31:0] b);
    longint unsigned am, bm, p, r;
    logic [31:0] na, nb, lo;
    na = -a;
    nb = -b;
    am = a[31] ? {32'h0, na} : {32'h0, a};
    bm = b[31] ? {32'h0, nb} : {32'h0, b};
    p  = am * bm;
    r  = (p + 64'd512) / 64'd1024;
    lo = r[31:0];
    if (a[31] ^ b[31]) begin
      if (r > 64'h8000_0000) return 32'h8000_0000;
      return -lo;
    end
    if (r > 64'h7FFF_FFFF) return 32'h7FFF_FFFF;
    return lo;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    logic [31:0] edges [7];
    edges = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1024, 32'hFFFF_FC00};
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 131071) - 32'd65536;
      2: v = edges[$urandom_range(0, 6)];
      default: begin
        v = $urandom & 32'h000F_FFFF;
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  // Runs one handshake; cyc is the cycle of valid_out counting acceptance as 0,
  // or 0 if no result appears within the bound.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cyc);
    int c;
    int guard;
    bit found;
    res = 32'h0;
    cyc = 0;
    guard = 0;
    found = 1'b0;
    @(negedge clock);
    while (!ready_out && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    multiplicand = a;
    multiplier   = b;
    valid_in     = 1'b1;
    @(posedge clock);
    c = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      valid_in = 1'b0;
      if (valid_out) begin
        found = 1'b1;
        break;
      end
      @(posedge clock);
      c++;
    end
    if (found) begin
      cyc = c;
      res = product;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid_in = 1'b0;
    multiplicand = 32'h0;
    multiplier = 32'h0;
    #12;
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_out); end
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    total++;
    if (product !== 32'h0) begin bad++; $display("FAIL reset_product got=%h want=0", product); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [9];
    logic [31:0] tb [9];
    logic [31:0] te [9];
    logic [31:0] res;
    int cyc;
    ta = '{32'd1536, -32'd1536, -32'd1536, 32'd512, 32'd511, -32'd512,
           32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    tb = '{32'd2048, 32'd2048, -32'd2048, 32'd1, 32'd1, 32'd1,
           32'h7FFF_FFFF, 32'd1024, -32'd1024};
    te = '{32'd3072, -32'd3072, 32'd3072, 32'd1, 32'd0, 32'hFFFF_FFFF,
           32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 9; i++) begin
      do_mult(ta[i], tb[i], res, cyc);
      total++;
      if (res !== te[i]) begin
        bad++;
        $display("FAIL directed_%0d product got=%h want=%h", i, res, te[i]);
      end
      total++;
      if (cyc != 33) begin
        bad++;
        $display("FAIL directed_%0d latency got=%0d want=33", i, cyc);
      end
      @(negedge clock);
      total++;
      if ({ready_out, valid_out, product} !== {1'b1, 1'b0, te[i]}) begin
        bad++;
        $display("FAIL directed_%0d after_done ready=%b valid=%b product=%h want ready=1 valid=0 product=%h",
                 i, ready_out, valid_out, product, te[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    int cyc;
    for (int i = 0; i < 25; i++) begin
      a = rand_operand();
      b = rand_operand();
      exp = model_mult(a, b);
      do_mult(a, b, res, cyc);
      total++;
      if (res !== exp || cyc != 33) begin
        bad++;
        $display("FAIL random_%0d a=%h b=%h got=%h cyc=%0d want=%h cyc=33", i, a, b, res, cyc, exp);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int guard;
    int pulses;
    logic [31:0] seen;
    guard = 0;
    seen = 32'h0;
    @(negedge clock);
    while (!ready_out && guard < 100) begin @(negedge clock); guard++; end
    multiplicand = 32'd1536;
    multiplier = 32'd2048;
    valid_in = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_in = 1'b0;
    repeat (5) @(negedge clock);
    multiplicand = 32'h7FFF_FFFF;
    multiplier = 32'h0000_0400;
    valid_in = 1'b1;
    total++;
    if (ready_out !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", ready_out); end
    @(negedge clock);
    valid_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (valid_out) begin
        pulses++;
        if (pulses == 1) seen = product;
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL busy_pulses got=%0d want=1", pulses); end
    total++;
    if (seen !== 32'd3072) begin bad++; $display("FAIL busy_product got=%h want=%h", seen, 32'd3072); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    int guard;
    int gap;
    bit found;
    a1 = rand_operand();
    b1 = rand_operand();
    a2 = rand_operand();
    b2 = rand_operand();
    guard = 0;
    @(negedge clock);
    while (!ready_out && guard < 100) begin @(negedge clock); guard++; end
    multiplicand = a1;
    multiplier = b1;
    valid_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (valid_out) begin found = 1'b1; break; end
    end
    total++;
    if (!found || product !== model_mult(a1, b1)) begin
      bad++;
      $display("FAIL b2b_first found=%b got=%h want=%h", found, product, model_mult(a1, b1));
    end
    multiplicand = a2;
    multiplier = b2;
    gap = 0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      gap++;
      if (valid_out) begin found = 1'b1; break; end
    end
    valid_in = 1'b0;
    total++;
    if (!found || gap != 34 || product !== model_mult(a2, b2)) begin
      bad++;
      $display("FAIL b2b_second found=%b gap=%0d got=%h want gap=34 product=%h",
               found, gap, product, model_mult(a2, b2));
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    int pulses;
    logic [31:0] res;
    int cyc;
    guard = 0;
    @(negedge clock);
    while (!ready_out && guard < 100) begin @(negedge clock); guard++; end
    multiplicand = 32'd1536;
    multiplier = 32'd2048;
    valid_in = 1'b1;
    @(posedge clock);
    #1 valid_in = 1'b0;
    repeat (9) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({ready_out, valid_out, product} !== {1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL midreset_state ready=%b valid=%b product=%h want ready=1 valid=0 product=0",
               ready_out, valid_out, product);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (valid_out) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL midreset_pulses got=%0d want=0", pulses); end
    do_mult(-32'd1536, -32'd2048, res, cyc);
    total++;
    if (res !== 32'd3072 || cyc != 33) begin
      bad++;
      $display("FAIL midreset_next got=%h cyc=%0d want=%h cyc=33", res, cyc, 32'd3072);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
